mem_bus_responder: RTL and testbench

//  Memory-side responder for the 64-bit main bus. Bus masters (line fill, line flush) use it to read and write 64-byte cache lines.

---
 rtl/mem_bus_responder.sv | 122 ++++++++++++
 tb/tb_mem_bus_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the 64-bit main bus: one request at a time,
// 8-beat cache line bursts backed by an internal word array.
module mem_bus_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int READ_LATENCY   = 4,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack,
    output logic                      busy
);

    localparam int AW   = $clog2(MEM_WORDS);
    localparam int BW   = $clog2(BEATS);
    localparam int LO   = $clog2(BEATS * BUS_DATA_WIDTH / 8);
    localparam int LW   = AW - BW;
    localparam int LATW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WR_DATA,
        RD_WAIT,
        RD_RESP
    } state_t;

    state_t                    state;
    logic [LW-1:0]             line;
    logic [BW-1:0]             beat;
    logic [BW-1:0]             beat_nx;
    logic [LATW-1:0]           lat;
    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic                      take;
    logic                      wr_en;
    logic                      last;

    // The master holds a beat until it sees the registered ack, so the
    // beat still on the bus during the ack cycle must not be taken again.
    assign take    = bus_reqcyc && !bus_reqack;
    assign wr_en   = (state == WR_DATA) && take;
    assign beat_nx = beat + BW'(1);
    assign last    = (beat == BW'(BEATS - 1));
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{line, beat}] <= bus_req;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            line        <= '0;
            beat        <= '0;
            lat         <= '0;
            bus_reqack  <= 1'b0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
        end else begin
            bus_reqack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        line       <= bus_req[LO +: LW];
                        beat       <= '0;
                        bus_reqack <= 1'b1;
                        if (bus_reqtag[BUS_TAG_WIDTH-1]) begin
                            state <= WR_DATA;
                        end else begin
                            state       <= RD_WAIT;
                            lat         <= LATW'(READ_LATENCY - 1);
                            bus_resptag <= bus_reqtag;
                        end
                    end
                end
                WR_DATA: begin
                    if (take) begin
                        bus_reqack <= 1'b1;
                        beat       <= beat_nx;
                        if (last) begin
                            state <= IDLE;
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat == '0) begin
                        state       <= RD_RESP;
                        beat        <= '0;
                        bus_respcyc <= 1'b1;
                        bus_resp    <= mem[{line, BW'(0)}];
                    end else begin
                        lat <= lat - LATW'(1);
                    end
                end
                RD_RESP: begin
                    if (bus_respack) begin
                        if (last) begin
                            state       <= IDLE;
                            bus_respcyc <= 1'b0;
                        end else begin
                            beat     <= beat_nx;
                            bus_resp <= mem[{line, beat_nx}];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: line writes, reads, stalls,
// gapped writes, requests during reads, mid-burst reset and wrap-around.
module tb_mem_bus_responder;

    typedef logic [63:0] line_t [8];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bus_reqcyc = 1'b0;
    logic [63:0] bus_req = '0;
    logic [12:0] bus_reqtag = '0;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack = 1'b0;
    logic        busy;

    int total = 0;
    int bad = 0;
    int ack_cnt = 0;
    int both_cnt = 0;

    mem_bus_responder dut (
        .clk(clk),
        .reset(reset),
        .bus_reqcyc(bus_reqcyc),
        .bus_req(bus_req),
        .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc),
        .bus_resp(bus_resp),
        .bus_resptag(bus_resptag),
        .bus_respack(bus_respack),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Sampled on the edge that ends each cycle: one count per ack cycle.
    always @(posedge clk) begin
        if (bus_reqack) ack_cnt++;
        if (bus_reqack && bus_respcyc) both_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [12:0] t);
        int n = 0;
        bus_reqcyc = 1'b1;
        bus_req    = d;
        bus_reqtag = t;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_reqack && n < 50);
        if (!bus_reqack) chk("ack_timeout", 64'd0, 64'd1);
        bus_reqcyc = 1'b0;
    endtask

    task automatic wr_line(input logic [63:0] a, input logic [11:0] id,
                           input line_t d, input logic [7:0] gap);
        send(a, {1'b1, id});
        for (int b = 0; b < 8; b++) begin
            if (gap[b]) repeat (2) @(negedge clk);
            send(d[b], {1'b1, id});
        end
    endtask

    task automatic rd_data(input line_t d, input logic [11:0] id,
                           input int stall_at, input int stall_n,
                           input int stop_at);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_respcyc && n < 50);
        chk("rd_lat", 64'(n), 64'd4);
        chk("resptag", 64'(bus_resptag), 64'({1'b0, id}));
        for (int b = 0; b < 8; b++) begin
            chk("respcyc", 64'(bus_respcyc), 64'd1);
            chk("rd_beat", bus_resp, d[b]);
            if (b == stop_at) begin
                bus_respack = 1'b0;
                return;
            end
            if (b == stall_at) begin
                bus_respack = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    chk("stall_hold", bus_resp, d[b]);
                end
            end
            bus_respack = 1'b1;
            @(negedge clk);
        end
        bus_respack = 1'b0;
        chk("resp_end", 64'(bus_respcyc), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        line_t d1;
        line_t d4;
        line_t d0;
        int c0;
        int n;
        for (int b = 0; b < 8; b++) begin
            d1[b] = 64'h11 * 64'(b + 1);
            d4[b] = 64'hA5A5_0000_0000_0000 + 64'(b);
            d0[b] = 64'hC0DE_0000_0000_0000 + 64'(b * 3 + 1);
        end

        repeat (2) @(negedge clk);
        chk("rst_reqack", 64'(bus_reqack), 64'd0);
        chk("rst_respcyc", 64'(bus_respcyc), 64'd0);
        chk("rst_resp", bus_resp, 64'd0);
        chk("rst_resptag", 64'(bus_resptag), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Write then read one line.
        wr_line(64'h1000, 12'h3A5, d1, 8'h00);
        send(64'h1000, {1'b0, 12'h0C1});
        rd_data(d1, 12'h0C1, -1, 0, 8);

        // Low offset bits ignored.
        send(64'h1028, {1'b0, 12'h7FF});
        rd_data(d1, 12'h7FF, -1, 0, 8);

        // Master stalls 3 cycles on beat 2.
        send(64'h1000, {1'b0, 12'h002});
        rd_data(d1, 12'h002, 2, 3, 8);

        // Gapped write: address ack plus 8 data acks.
        c0 = ack_cnt;
        wr_line(64'h2000, 12'h444, d4, 8'b0100_1000);
        @(negedge clk);
        chk("wr_acks", 64'(ack_cnt - c0), 64'd9);
        send(64'h2000, {1'b0, 12'h555});
        rd_data(d4, 12'h555, -1, 0, 8);

        // Request held during a read: only the read's own ack is seen.
        send(64'h1000, {1'b0, 12'h0AA});
        c0 = ack_cnt;
        bus_reqcyc = 1'b1;
        bus_req    = 64'h2000;
        bus_reqtag = {1'b0, 12'h0BB};
        rd_data(d1, 12'h0AA, -1, 0, 8);
        chk("no_ack_in_rd", 64'(ack_cnt - c0), 64'd1);
        n = 0;
        while (!bus_reqack && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("late_ack", 64'(n), 64'd1);
        bus_reqcyc = 1'b0;
        rd_data(d4, 12'h0BB, -1, 0, 8);

        // Reset on beat 4 of a read.
        send(64'h1000, {1'b0, 12'h0CC});
        rd_data(d1, 12'h0CC, -1, 0, 4);
        reset = 1'b0;
        #1;
        chk("arst_respcyc", 64'(bus_respcyc), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_resp", bus_resp, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(64'h1000, {1'b0, 12'h0DD});
        rd_data(d1, 12'h0DD, -1, 0, 8);

        // 0x8000 wraps onto word 0 with 4096 words.
        wr_line(64'h0, 12'h0EE, d0, 8'h00);
        send(64'h8000, {1'b0, 12'h0EF});
        rd_data(d0, 12'h0EF, -1, 0, 8);

        chk("never_both", 64'(both_cnt), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
